// File: rtl/uart_boot_loader.sv
// Boot-image loader: frames UART bytes (A5, LEN, 4*LEN data, CSUM) into 32-bit
// little-endian instruction writes and holds the CPU in reset until a clean load.
module uart_boot_loader #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_wd,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [31:0]   rx_check
);

    localparam logic [7:0] MAGIC = 8'hA5;
    localparam int         TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state, state_nx;
    logic [1:0]      idx;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   last_adr;
    logic [AW-1:0]   last_adr_nx;
    logic [7:0]      csum;
    logic [23:0]     lanes;
    logic [TW-1:0]   idle_cnt;
    logic            magic;
    logic            in_frame;
    logic            timed_out;
    logic            word_end;
    int              len_words;

    assign magic     = rx_valid && (rx_data == MAGIC);
    assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign timed_out = in_frame && !rx_valid && (idle_cnt == TW'(TIMEOUT - 1));
    assign word_end  = (state == S_DATA) && rx_valid && (idx == 2'd3);

    // LEN=0 encodes 256 words; the count is then clipped to the address space.
    always_comb begin
        len_words = (rx_data == 8'd0) ? 256 : int'(rx_data);
        if (len_words > (1 << AW)) len_words = 1 << AW;
        last_adr_nx = AW'(len_words - 1);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        if (timed_out) begin
            state_nx = S_ERR;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: if (magic) state_nx = S_LEN;
                S_LEN:  if (rx_valid) state_nx = S_DATA;
                S_DATA: if (word_end && (addr == last_adr)) state_nx = S_CSUM;
                S_CSUM: if (rx_valid) state_nx = (rx_data == csum) ? S_DONE : S_ERR;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we   <= 1'b0;
            mem_adr  <= '0;
            mem_wd   <= '0;
            rx_check <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            idx      <= '0;
            addr     <= '0;
            last_adr <= '0;
            csum     <= '0;
            lanes    <= '0;
            idle_cnt <= '0;
        end else begin
            mem_we <= 1'b0;

            if (in_frame && !rx_valid) idle_cnt <= idle_cnt + 1'b1;
            else                       idle_cnt <= '0;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (magic) begin
                        error    <= 1'b0;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                    end else if (state == S_DONE) begin
                        cpu_hold <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        last_adr <= last_adr_nx;
                        idx      <= '0;
                        addr     <= '0;
                        csum     <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        csum <= csum ^ rx_data;
                        idx  <= idx + 2'd1;
                        case (idx)
                            2'd0: lanes[7:0]   <= rx_data;
                            2'd1: lanes[15:8]  <= rx_data;
                            2'd2: lanes[23:16] <= rx_data;
                            default: begin
                                // Fourth byte completes the word: write it on the next cycle.
                                mem_we   <= 1'b1;
                                mem_adr  <= addr;
                                mem_wd   <= {rx_data, lanes};
                                rx_check <= {rx_data, lanes};
                                addr     <= addr + 1'b1;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum) done  <= 1'b1;
                        else                 error <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (timed_out) error <= 1'b1;
        end
    end

endmodule
